// File: rtl/child_bist_if.sv
// Pin bundle between the child_bist sequencer (master) and the logic cell / test harness (slave).
// start is a level sampled only while the sequencer is idle; done is a one-cycle completion pulse with the sweep results held afterwards.
interface child_bist_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             result;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [2:0]       fail_vec;

    modport master (
        input  start, result,
        output a, b, c, busy, done, pass, err_cnt, fail_valid, fail_vec
    );

    modport slave (
        output start, result,
        input  a, b, c, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
endinterface

// File: rtl/child_bist.sv
// Self-test sequencer for the a & (b | c) cell: sweeps all 8 vectors, samples result
// SETTLE cycles after each one and reports error count, first failing vector and pass flag.
module child_bist #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    child_bist_if.master      bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       vec;
    logic [3:0]       settle_cnt;
    logic [2:0]       abc;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [2:0]       fail_vec;

    logic             exp_bit;
    logic             mismatch;
    logic             sample_now;
    logic [ERR_W-1:0] err_next;

    // err_next already includes the compare made this cycle, so pass can be taken from it on entry to DONE.
    always_comb begin
        exp_bit    = vec[2] & (vec[1] | vec[0]);
        mismatch   = bus.result ^ exp_bit;
        sample_now = (settle_cnt == 4'(SETTLE));
        err_next   = err_cnt;
        if (mismatch && (err_cnt != {ERR_W{1'b1}}))
            err_next = err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            abc        <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    abc  <= 3'd0;
                    if (bus.start) begin
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 3'd0;
                        pass       <= 1'b0;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd1;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!sample_now) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        err_cnt <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                        end
                        if (vec == 3'd7) begin
                            abc   <= 3'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                            state <= DONE;
                        end else begin
                            vec        <= vec + 3'd1;
                            abc        <= vec + 3'd1;
                            settle_cnt <= 4'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    abc   <= 3'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a          = abc[2];
    assign bus.b          = abc[1];
    assign bus.c          = abc[0];
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_cnt    = err_cnt;
    assign bus.fail_valid = fail_valid;
    assign bus.fail_vec   = fail_vec;
    assign dbg_state      = state;
endmodule

// File: tb/tb_child_bist.sv
// Bench for child_bist: four instances (SETTLE/ERR_W/cell-latency variants) driven by a fault-injecting
// cell model; every sweep is predicted from the vector timing rules and the golden table.
module tb_child_bist;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start [4];
  logic [1:0] mode;
  logic [2:0] fvec;

  logic [2:0] abc_w   [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic       pass_w  [4];
  logic       fv_w    [4];
  logic [3:0] err_w   [4];
  logic [2:0] fvec_w  [4];
  logic [1:0] st_w    [4];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] golden = 8'b1110_0000;

  function automatic int settle_of(input int g);
    return (g == 2) ? 3 : (g == 3) ? 2 : 1;
  endfunction

  function automatic int errw_of(input int g);
    return (g == 1) ? 2 : 4;
  endfunction

  function automatic int lat_of(input int g);
    return (g >= 2) ? 2 : 0;
  endfunction

  // mode 0 good cell, 1 stuck-at-0, 2 stuck-at-1, 3 output inverted for one vector
  function automatic logic cell_fn(input logic [1:0] m, input logic [2:0] fv, input logic [2:0] v);
    logic good;
    good = v[2] & (v[1] | v[0]);
    case (m)
      2'd0: return good;
      2'd1: return 1'b0;
      2'd2: return 1'b1;
      default: return good ^ (v == fv);
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int S   = settle_of(g);
    localparam int EW  = errw_of(g);
    localparam int LAT = lat_of(g);

    child_bist_if #(.ERR_W(EW)) bus ();
    logic f;
    logic r1 = 1'b0;
    logic r2 = 1'b0;

    assign f = cell_fn(mode, fvec, {bus.a, bus.b, bus.c});
    always @(posedge clk) begin
      r1 <= f;
      r2 <= r1;
    end
    assign bus.result = (LAT == 2) ? r2 : f;
    assign bus.start  = start[g];

    child_bist #(.SETTLE(S), .ERR_W(EW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .dbg_state (st_w[g])
    );

    assign abc_w[g]  = {bus.a, bus.b, bus.c};
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign pass_w[g] = bus.pass;
    assign fv_w[g]   = bus.fail_valid;
    assign err_w[g]  = 4'(bus.err_cnt);
    assign fvec_w[g] = bus.fail_vec;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predicts the per-cycle {busy,done,abc} trace and the final results, then runs one sweep.
  task automatic run_sweep(input int g, input logic [1:0] m, input logic [2:0] fv,
                           input bit hold, input bit no_wait);
    logic [4:0] exp_q[$];
    int s, lag, errs, first, idx, sat;
    logic smp;
    s   = settle_of(g);
    lag = lat_of(g) + 1 - s;
    if (lag < 0) lag = 0;
    if (!no_wait) begin
      @(negedge clk);
      mode = m;
      fvec = fv;
      repeat (3) @(negedge clk);
    end
    errs  = 0;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      idx = k - lag;
      if (idx < 0) idx = 0;
      smp = cell_fn(m, fv, 3'(idx));
      if (smp != golden[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    sat = (1 << errw_of(g)) - 1;
    for (int j = 0; j < 8 * s; j++) exp_q.push_back({1'b1, 1'b0, 3'(j / s)});
    exp_q.push_back({1'b0, 1'b1, 3'd0});

    start[g] = 1'b1;
    for (int j = 0; j <= 8 * s; j++) begin
      @(negedge clk);
      if (!hold) start[g] = 1'b0;
      check($sformatf("seq%0d_j%0d", g, j), {27'd0, busy_w[g], done_w[g], abc_w[g]}, {27'd0, exp_q.pop_front()});
    end
    check($sformatf("err%0d", g),   err_w[g],  (errs > sat) ? sat : errs);
    check($sformatf("fvalid%0d", g), fv_w[g],  (errs > 0));
    check($sformatf("fvec%0d", g),  fvec_w[g], (first < 0) ? 0 : first);
    check($sformatf("pass%0d", g),  pass_w[g], (errs == 0));
  endtask

  initial begin
    int seen_done;
    rst  = 1'b1;
    mode = 2'd0;
    fvec = 3'd0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_abc",  abc_w[i],  0);
      check("rst_busy", busy_w[i], 0);
      check("rst_done", done_w[i], 0);
      check("rst_pass", pass_w[i], 0);
      check("rst_err",  err_w[i],  0);
      check("rst_fv",   fv_w[i],   0);
      check("rst_fvec", fvec_w[i], 0);
    end
    rst = 1'b0;

    run_sweep(0, 2'd0, 3'd0, 1'b0, 1'b0);
    run_sweep(0, 2'd1, 3'd0, 1'b0, 1'b0);
    run_sweep(0, 2'd2, 3'd0, 1'b0, 1'b0);
    run_sweep(1, 2'd2, 3'd0, 1'b0, 1'b0);
    run_sweep(2, 2'd0, 3'd0, 1'b0, 1'b0);
    run_sweep(3, 2'd0, 3'd0, 1'b0, 1'b0);

    // start held high: one sweep, then a gap cycle, then the next sweep
    run_sweep(0, 2'd0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("gap_busy", busy_w[0], 0);
    check("gap_done", done_w[0], 0);
    run_sweep(0, 2'd0, 3'd0, 1'b0, 1'b1);

    // asynchronous reset while vector 4 is applied
    @(negedge clk);
    mode = 2'd2;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("prerst_abc", abc_w[0], 4);
    check("prerst_err", err_w[0], 4);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_w[0], 0);
    check("midrst_abc",  abc_w[0],  0);
    check("midrst_err",  err_w[0],  0);
    check("midrst_done", done_w[0], 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) seen_done++;
    end
    check("postrst_idle", seen_done, 0);
    run_sweep(0, 2'd0, 3'd0, 1'b0, 1'b0);

    repeat (12) begin
      run_sweep($urandom_range(0, 3), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
